seg7_scan_ctrl: RTL and testbench
=================================

// Module: seg7_scan_ctrl
// PURPOSE
//  Memory-mapped 7-segment display controller on the LSU store/load bus.
//  Holds one segment pattern per digit. Time-multiplexes the digits onto a shared
//  active-low segment bus, with a blanking gap between digits to suppress ghosting.
//  Load readback returns the stored value; the LSU merges it when o_ld_hit=1.
// PARAMETERS
//  NUM_DIGITS    8              digits scanned, 2..8
//  REFRESH_DIV   50000          cycles each digit is lit (SHOW), >=2
//  BLANK_CYCLES  16             all-off cycles between digits (BLANK), >=1
//  BASE_ADDR     32'h0000_7020  digit k at BASE_ADDR+4*k
//  CTRL_ADDR     32'h0000_7040  control reg, bit0 = scan enable
// PORTS
//  i_clk       in   1           system clock, rising edge
//  i_rst       in   1           synchronous reset, active-high
//  i_st_en     in   1           store strobe, one write per cycle
//  i_lsu_addr  in   32          LSU byte address (bits[1:0] ignored)
//  i_st_data   in   32          store data
//  o_ld_data   out  32          readback, combinational from i_lsu_addr
//  o_ld_hit    out  1           i_lsu_addr decodes to a digit or CTRL_ADDR
//  o_seg       out  7           segments g..a, active-low, registered
//  o_dig_en    out  NUM_DIGITS  digit enables, active-low, one-hot-low, registered
//  o_frame     out  1           1-cycle pulse when digit index wraps to 0
// BEHAVIOUR
//  Reset:
//   - all digit regs = 7'h7F; en = 0; FSM = IDLE; index = 0; counter = 0.
//   - o_seg = 7'h7F, o_dig_en = all 1s, o_frame = 0.
//  Writes:
//   - i_st_en & digit address k<NUM_DIGITS -> reg[k] <= i_st_data[6:0] at that edge.
//   - A digit address with k>=NUM_DIGITS is ignored.
//   - A CTRL_ADDR write -> en <= i_st_data[0].
//  Reads:
//   - digit -> {25'b0, reg[k]}; CTRL -> {31'b0, en}.
//   - Any other address -> o_ld_data=0, o_ld_hit=0.
//  FSM, counter resets to 0 on each state entry:
//   - IDLE: outputs all off. en=1 -> BLANK with index=0.
//   - BLANK: outputs all off. After BLANK_CYCLES cycles -> SHOW.
//   - SHOW: o_dig_en[index]=0, o_seg=reg[index]. After REFRESH_DIV cycles:
//     -> BLANK with index+1; NUM_DIGITS-1 wraps to 0 and pulses o_frame in the
//     first BLANK cycle.
//  Latency:
//   - outputs register FSM/reg state one cycle late.
//   - A write to the lit digit appears on o_seg at the edge after the write edge.
//  en cleared mid-scan (any state):
//   - FSM -> IDLE on the next edge; outputs all off one edge later.
//   - index resets to 0; a restart always begins at digit 0 with BLANK.
//  i_rst mid-scan: the full reset state is applied on that edge, including digit regs.
//  Only one write per cycle exists, so there is no store/store contention.
//  A store during SHOW does not disturb counter or index.
// CONFIGURATION
//  SEG7_HEX_DECODE_EN defined:
//   - digit writes store i_st_data[3:0] as a hex nibble; readback = {28'b0, nibble}.
//   - Reset nibble = 4'h0, but the digit stays blanked until first written; a
//     per-digit valid bit is cleared by reset and set by write.
//   - o_seg = active-low hex encoding of the nibble:
//     0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 B=03 C=46 D=21 E=06 F=0E.
//  Undefined: raw 7-bit patterns are stored and read back unchanged, no decode logic.
// TESTING
//  Bench parameters: NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=2, macro undefined
//  unless noted.
//  - Reset:
//    i_rst=1 for 2 cycles -> o_seg=7F, o_dig_en=4'hF, o_frame=0; read 0x7020 -> 0x7F, hit=1.
//  - Scan:
//    write 0x7020=0x40, 0x7024=0x79, CTRL=1 -> per digit 2 cycles dig_en=F then 4
//    cycles dig_en=E/D/B/7 with seg=40/79/7F/7F; o_frame pulses once per 24-cycle frame.
//  - Live update:
//    while digit1 lit, write 0x7024=0x24 -> o_seg=24 on the next edge; dig_en unchanged,
//    dwell still 4 cycles.
//  - Disable mid-SHOW:
//    write CTRL=0 in SHOW cycle 2 -> all off within 2 edges. Re-enable -> 2 blank
//    cycles, then digit 0.
//  - Decode:
//    read 0x7030 (k=4) -> hit=1, data=0 (out of range, not written).
//    read 0x7050 -> hit=0. Write 0x7030 -> no state change.
//  - With SEG7_HEX_DECODE_EN:
//    write 0x7020=0xA -> digit0 lit with seg=08, readback 0xA.
//    Unwritten digits stay 7F.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// Memory-mapped multiplexed 7-segment display controller with blanking gaps.
// Define SEG7_HEX_DECODE_EN to store hex nibbles and decode them to segments.
module seg7_scan_ctrl #(
    parameter int          NUM_DIGITS   = 8,
    parameter int          REFRESH_DIV  = 50000,
    parameter int          BLANK_CYCLES = 16,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_7020,
    parameter logic [31:0] CTRL_ADDR    = 32'h0000_7040
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_st_en,
    input  logic [31:0]           i_lsu_addr,
    input  logic [31:0]           i_st_data,
    output logic [31:0]           o_ld_data,
    output logic                  o_ld_hit,
    output logic [6:0]            o_seg,
    output logic [NUM_DIGITS-1:0] o_dig_en,
    output logic                  o_frame
);

    localparam int IW   = $clog2(NUM_DIGITS);
    localparam int CMAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW   = $clog2(CMAX);
    localparam logic [3:0] ND = 4'(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] ONE = NUM_DIGITS'(1);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_e;

    state_e                state_q;
    logic [IW-1:0]         idx_q;
    logic [CW-1:0]         cnt_q;
    logic                  en_q;
    logic                  wrap_q;
    logic [6:0]            seg_q;
    logic [NUM_DIGITS-1:0] dig_q;
    logic                  frame_q;

    logic [29:0]   off_w;
    logic          dig_sel;
    logic          ctrl_sel;
    logic          k_ok;
    logic [2:0]    k;
    logic [IW-1:0] k_idx;
    logic [6:0]    seg_lit;
    logic [31:0]   rd_val;

    // The digit window spans 8 word slots; slots past NUM_DIGITS hit but read 0.
    assign off_w    = i_lsu_addr[31:2] - BASE_ADDR[31:2];
    assign dig_sel  = off_w < 30'd8;
    assign k        = off_w[2:0];
    assign k_idx    = k[IW-1:0];
    assign k_ok     = dig_sel && ({1'b0, k} < ND);
    assign ctrl_sel = i_lsu_addr[31:2] == CTRL_ADDR[31:2];

`ifdef SEG7_HEX_DECODE_EN
    logic [3:0]            nib_q [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] vld_q;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    assign seg_lit = vld_q[idx_q] ? hex7(nib_q[idx_q]) : 7'h7F;
    assign rd_val  = {28'b0, nib_q[k_idx]};

    logic unused_bits;
    assign unused_bits = ^{i_lsu_addr[1:0], i_st_data[31:4]};
`else
    logic [6:0] pat_q [NUM_DIGITS];

    assign seg_lit = pat_q[idx_q];
    assign rd_val  = {25'b0, pat_q[k_idx]};

    logic unused_bits;
    assign unused_bits = ^{i_lsu_addr[1:0], i_st_data[31:7]};
`endif

    always_comb begin
        o_ld_data = '0;
        o_ld_hit  = dig_sel | ctrl_sel;
        if (ctrl_sel) begin
            o_ld_data = {31'b0, en_q};
        end else if (k_ok) begin
            o_ld_data = rd_val;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
`ifdef SEG7_HEX_DECODE_EN
                nib_q[i] <= 4'h0;
`else
                pat_q[i] <= 7'h7F;
`endif
            end
`ifdef SEG7_HEX_DECODE_EN
            vld_q   <= '0;
`endif
            en_q    <= 1'b0;
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
            seg_q   <= 7'h7F;
            dig_q   <= '1;
            frame_q <= 1'b0;
        end else begin
            if (i_st_en && k_ok) begin
`ifdef SEG7_HEX_DECODE_EN
                nib_q[k_idx] <= i_st_data[3:0];
                vld_q[k_idx] <= 1'b1;
`else
                pat_q[k_idx] <= i_st_data[6:0];
`endif
            end
            if (i_st_en && ctrl_sel) begin
                en_q <= i_st_data[0];
            end

            // Outputs follow the state one cycle late.
            seg_q   <= (state_q == SHOW) ? seg_lit : 7'h7F;
            dig_q   <= (state_q == SHOW) ? ~(ONE << idx_q) : '1;
            frame_q <= wrap_q;
            wrap_q  <= 1'b0;

            if (!en_q) begin
                state_q <= IDLE;
                idx_q   <= '0;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= BLANK;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                    end
                    BLANK: begin
                        if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
                            state_q <= SHOW;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    SHOW: begin
                        if (cnt_q == CW'(REFRESH_DIV - 1)) begin
                            state_q <= BLANK;
                            cnt_q   <= '0;
                            if (idx_q == IW'(NUM_DIGITS - 1)) begin
                                idx_q  <= '0;
                                wrap_q <= 1'b1;
                            end else begin
                                idx_q <= idx_q + 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign o_seg    = seg_q;
    assign o_dig_en = dig_q;
    assign o_frame  = frame_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: read-decode table, scan sequences, random stores
// checked against a time-based model of the scan schedule.
module tb_seg7_scan_ctrl;

    localparam int N = 4;
    localparam int R = 4;
    localparam int B = 2;
    localparam int P = B + R;

`ifdef SEG7_HEX_DECODE_EN
    localparam logic [31:0] RST_RD = 32'h0;
    localparam logic [6:0]  LIVE_SEG = 7'h19;
`else
    localparam logic [31:0] RST_RD = 32'h7F;
    localparam logic [6:0]  LIVE_SEG = 7'h24;
`endif

    logic        clk;
    logic        rst;
    logic        st_en;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] ld_data;
    logic        ld_hit;
    logic [6:0]  seg;
    logic [N-1:0] dig_en;
    logic        frame;

    seg7_scan_ctrl #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (R),
        .BLANK_CYCLES(B)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_st_en   (st_en),
        .i_lsu_addr(addr),
        .i_st_data (sdata),
        .o_ld_data (ld_data),
        .o_ld_hit  (ld_hit),
        .o_seg     (seg),
        .o_dig_en  (dig_en),
        .o_frame   (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: stored values, enable, and time since the scan last (re)started.
    int  m_reg [N];
    bit  m_vld [N];
    bit  m_en;
    bit  m_run;
    int  m_t;
    logic [6:0]   exp_seg;
    logic [N-1:0] exp_dig;
    logic         exp_frame;

    int hex_lut [16] = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78,
                         'h00, 'h10, 'h08, 'h03, 'h46, 'h21, 'h06, 'h0E};

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int mdl_seg(input int d);
`ifdef SEG7_HEX_DECODE_EN
        return m_vld[d] ? hex_lut[m_reg[d]] : 'h7F;
`else
        return m_reg[d];
`endif
    endfunction

    task automatic mdl_read(input logic [31:0] a, output logic [31:0] d,
                            output logic h);
        logic [31:0] w;
        int kk;
        w = a & 32'hFFFF_FFFC;
        d = 0;
        h = 0;
        if (w >= 32'h7020 && w < 32'h7040) begin
            h = 1;
            kk = int'((w - 32'h7020) / 4);
            if (kk < N) d = m_reg[kk];
        end else if (w == 32'h7040) begin
            h = 1;
            d = {31'b0, m_en};
        end
    endtask

    task automatic mdl_step(input bit r, input bit s, input logic [31:0] a,
                            input logic [31:0] d);
        logic [31:0] w;
        int kk;
        bit lit;
        int dd;
        if (r) begin
            for (int i = 0; i < N; i++) begin
                m_reg[i] = int'(RST_RD);
                m_vld[i] = 0;
            end
            m_en = 0; m_run = 0; m_t = 0;
            exp_seg = 7'h7F; exp_dig = '1; exp_frame = 0;
            return;
        end
        lit = m_run && (m_t % P) >= B;
        dd  = (m_t / P) % N;
        exp_seg   = lit ? 7'(mdl_seg(dd)) : 7'h7F;
        exp_dig   = lit ? ~(N'(1) << dd) : '1;
        exp_frame = m_run && m_t > 0 && (m_t % (N * P)) == 0;
        if (!m_en) begin
            m_run = 0; m_t = 0;
        end else if (!m_run) begin
            m_run = 1; m_t = 0;
        end else begin
            m_t++;
        end
        if (s) begin
            w = a & 32'hFFFF_FFFC;
            if (w >= 32'h7020 && w < 32'h7040) begin
                kk = int'((w - 32'h7020) / 4);
                if (kk < N) begin
`ifdef SEG7_HEX_DECODE_EN
                    m_reg[kk] = int'(d & 32'hF);
`else
                    m_reg[kk] = int'(d & 32'h7F);
`endif
                    m_vld[kk] = 1;
                end
            end else if (w == 32'h7040) begin
                m_en = d[0];
            end
        end
    endtask

    task automatic cyc(input bit r, input bit s, input logic [31:0] a,
                       input logic [31:0] d);
        logic [31:0] ed;
        logic eh;
        rst = r; st_en = s; addr = a; sdata = d;
        #1;
        mdl_read(a, ed, eh);
        chk("ld_data", ld_data, ed);
        chk("ld_hit", {31'b0, ld_hit}, {31'b0, eh});
        @(posedge clk);
        mdl_step(r, s, a, d);
        #1;
        chk("seg", {25'b0, seg}, {25'b0, exp_seg});
        chk("dig_en", {28'b0, dig_en}, {28'b0, exp_dig});
        chk("frame", {31'b0, frame}, {31'b0, exp_frame});
    endtask

    task automatic idle();
        cyc(0, 0, 32'h7020 + 4 * ($urandom % 9), 0);
    endtask

    task automatic wait_edge(input logic [N-1:0] v, input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            if (dig_en != v) begin ok = 1; break; end
            idle();
        end
        if (ok) begin
            ok = 0;
            for (int i = 0; i < 60; i++) begin
                if (dig_en == v) begin ok = 1; break; end
                idle();
            end
        end
        chk(name, {31'b0, ok}, 32'd1);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic        h;
    } rd_vec_t;

    rd_vec_t tv [7];

    initial begin
        int nf, ne, nff, ne40, lastf, dw, offs;
        bit r, s;
        int sel;
        logic [31:0] a, d;

        tv[0] = '{32'h7020, RST_RD, 1'b1};
        tv[1] = '{32'h7022, RST_RD, 1'b1};
        tv[2] = '{32'h7030, 32'h0,  1'b1};
        tv[3] = '{32'h703C, 32'h0,  1'b1};
        tv[4] = '{32'h7040, 32'h0,  1'b1};
        tv[5] = '{32'h7050, 32'h0,  1'b0};
        tv[6] = '{32'h701C, 32'h0,  1'b0};

        rst = 1; st_en = 0; addr = 0; sdata = 0;
        for (int i = 0; i < N; i++) begin m_reg[i] = 0; m_vld[i] = 0; end
        m_en = 0; m_run = 0; m_t = 0;

        cyc(1, 0, 32'h7020, 0);
        cyc(1, 0, 32'h7020, 0);
        chk("rst_seg", {25'b0, seg}, 32'h7F);
        chk("rst_dig", {28'b0, dig_en}, 32'hF);
        chk("rst_frame", {31'b0, frame}, 32'h0);

        rst = 0;
        foreach (tv[i]) begin
            addr = tv[i].a;
            #1;
            chk("tbl_data", ld_data, tv[i].d);
            chk("tbl_hit", {31'b0, ld_hit}, {31'b0, tv[i].h});
        end

        cyc(0, 1, 32'h7030, 32'h55);
        cyc(0, 0, 32'h7030, 0);
        chk("oor_rd", ld_data, 32'h0);

        // Basic scan
        cyc(0, 1, 32'h7020, 32'h40);
        cyc(0, 1, 32'h7024, 32'h79);
        cyc(0, 1, 32'h7040, 32'h1);
        for (int i = 0; i < 30; i++) idle();
        nf = 0; ne = 0; nff = 0; ne40 = 0; lastf = -1;
        for (int i = 0; i < 48; i++) begin
            idle();
            if (dig_en == 4'hE) ne++;
            if (dig_en == 4'hE && seg == 7'h40) ne40++;
            if (dig_en == 4'hF) nff++;
            if (frame) begin
                if (lastf >= 0) chk("frame_gap", i - lastf, 24);
                lastf = i;
                nf++;
            end
        end
        chk("frames", nf, 2);
        chk("dig0_cycles", ne, 8);
        chk("dig0_seg40", ne40, 8);
        chk("blank_cycles", nff, 16);

        // Live update while digit 1 is lit
        wait_edge(4'hD, "wait_d1");
        dw = 1;
        cyc(0, 1, 32'h7024, 32'h24);
        if (dig_en == 4'hD) dw++;
        idle();
        chk("live_seg", {25'b0, seg}, {25'b0, LIVE_SEG});
        if (dig_en == 4'hD) dw++;
        for (int i = 0; i < 8; i++) begin
            if (dig_en != 4'hD) break;
            idle();
            if (dig_en == 4'hD) dw++;
        end
        chk("live_dwell", dw, 4);

        // Disable in the second SHOW cycle, then restart
        wait_edge(4'hE, "wait_d0");
        idle();
        cyc(0, 1, 32'h7040, 32'h0);
        idle();
        idle();
        chk("dis_dig", {28'b0, dig_en}, 32'hF);
        chk("dis_seg", {25'b0, seg}, 32'h7F);
        idle();
        idle();
        cyc(0, 1, 32'h7040, 32'h1);
        offs = 0;
        for (int i = 0; i < 10; i++) begin
            idle();
            if (dig_en != 4'hF) break;
            offs++;
        end
        chk("restart_dig", {28'b0, dig_en}, 32'hE);
        chk("restart_offs", offs, 3);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            r = ($urandom % 100) == 0;
            s = ($urandom % 4) == 0;
            sel = int'($urandom % 12);
            if (sel < 8) a = 32'h7020 + 32'(4 * sel);
            else if (sel < 10) a = 32'h7040;
            else if (sel == 10) a = 32'h7050;
            else a = $urandom;
            a = a | 32'($urandom % 4);
            if (sel == 8 || sel == 9) d = (($urandom % 5) != 0) ? 32'h1 : 32'h0;
            else d = $urandom;
            cyc(r, s, a, d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
